// File: rtl/uart_frame_assembler.sv
// Assembles UART bytes into an {A, B, opcode} frame held until acknowledged.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_assembler #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [7:0]        i_data,
  input  logic              i_ack,
  output logic [DATA_W-1:0] o_data_A,
  output logic [DATA_W-1:0] o_data_B,
  output logic [OP_W-1:0]   o_data_OPCODE,
  output logic              o_done,
  output logic              o_overrun,
  output logic              o_timeout
);

  localparam int NB          = DATA_W / 8;
  localparam int FRAME_BYTES = 2 * NB + 1;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  if (TIMEOUT_CYC < 2 || OP_W < 1 || OP_W > 8 || (DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 32)
    $error("uart_frame_assembler: illegal parameter value");

  typedef enum logic [1:0] {IDLE, COLLECT, VALID} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                overrun_q, overrun_d;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    overrun_d = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
    timeout_d = 1'b0;
    tmo_d     = (state_q == COLLECT && !i_rx_done && tmo_q != TMO_LAST) ? tmo_q + TMO_W'(1) : '0;
`endif
    case (state_q)
      IDLE, COLLECT: begin
        if (i_rx_done) begin
          if (cnt_q == LAST_IDX) begin
            // Final byte is the opcode; operands come from the buffered bytes.
            a_d     = buf_q[DATA_W-1:0];
            b_d     = buf_q[2*DATA_W-1:DATA_W];
            op_d    = i_data[OP_W-1:0];
            cnt_d   = '0;
            state_d = VALID;
          end else begin
            for (int unsigned i = 0; i < 2 * NB; i++)
              if (cnt_q == CNT_W'(i)) buf_d[i*8 +: 8] = i_data;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = COLLECT;
          end
        end
`ifdef UART_FRAME_TIMEOUT_EN
        else if (state_q == COLLECT && tmo_q == TMO_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      VALID: begin
        if (i_ack) begin
          state_d = IDLE;
          if (i_rx_done) begin
            buf_d[7:0] = i_data;
            cnt_d      = CNT_W'(1);
            state_d    = COLLECT;
          end
        end else if (i_rx_done) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_data_A      = a_q;
  assign o_data_B      = b_q;
  assign o_data_OPCODE = op_q;
  assign o_done        = (state_q == VALID);
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed self-checking bench for uart_frame_assembler (16-bit and 8-bit operand builds).
module tb_uart_frame_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  data = '0;
  logic        ack = 1'b0;
  logic [15:0] a, b;
  logic [5:0]  op;
  logic        done, overrun, timeout;

  logic        rx_done8 = 1'b0;
  logic [7:0]  data8 = '0;
  logic        ack8 = 1'b0;
  logic [7:0]  a8, b8, op8;
  logic        done8, overrun8, timeout8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_frame_assembler #(.DATA_W(16), .OP_W(6), .TIMEOUT_CYC(50)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done), .i_data(data), .i_ack(ack),
    .o_data_A(a), .o_data_B(b), .o_data_OPCODE(op),
    .o_done(done), .o_overrun(overrun), .o_timeout(timeout)
  );

  uart_frame_assembler #(.DATA_W(8), .OP_W(8), .TIMEOUT_CYC(50)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done8), .i_data(data8), .i_ack(ack8),
    .o_data_A(a8), .o_data_B(b8), .o_data_OPCODE(op8),
    .o_done(done8), .o_overrun(overrun8), .o_timeout(timeout8)
  );

  task automatic send_byte(input logic [7:0] v);
    @(negedge clk);
    rx_done = 1'b1;
    data    = v;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({a, b, op, done, overrun, timeout} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got A=%h B=%h OP=%h done=%b ovr=%b tmo=%b, want all 0",
               a, b, op, done, overrun, timeout);
    end
    tests++;
    if ({a8, b8, op8, done8} !== '0) begin
      fails++;
      $display("FAIL reset_outputs8: got A=%h B=%h OP=%h done=%b, want all 0", a8, b8, op8, done8);
    end
  endtask

  task automatic test_frame();
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL frame_done_early: got %b want 0", done); end
    send_byte(8'hE5);
    tests++;
    if ({done, a, b, op} !== {1'b1, 16'h1234, 16'h5678, 6'h25}) begin
      fails++;
      $display("FAIL frame_basic: got done=%b A=%h B=%h OP=%h, want 1 1234 5678 25", done, a, b, op);
    end
  endtask

  task automatic test_overrun();
    send_byte(8'h99);
    tests++;
    if ({overrun, done, a, b, op} !== {1'b1, 1'b1, 16'h1234, 16'h5678, 6'h25}) begin
      fails++;
      $display("FAIL overrun_pulse: got ovr=%b done=%b A=%h B=%h OP=%h, want 1 1 1234 5678 25",
               overrun, done, a, b, op);
    end
    @(negedge clk);
    tests++;
    if ({overrun, done} !== 2'b01) begin
      fails++;
      $display("FAIL overrun_once: got ovr=%b done=%b, want 0 1", overrun, done);
    end
  endtask

  task automatic test_ack_with_byte();
    @(negedge clk);
    ack = 1'b1; rx_done = 1'b1; data = 8'h01;
    @(negedge clk);
    ack = 1'b0; rx_done = 1'b0;
    tests++;
    if ({done, overrun, dut.cnt_q} !== {1'b0, 1'b0, 3'd1}) begin
      fails++;
      $display("FAIL ack_with_byte: got done=%b ovr=%b cnt=%0d, want 0 0 1", done, overrun, dut.cnt_q);
    end
    tests++;
    if ({a, b, op} !== {16'h1234, 16'h5678, 6'h25}) begin
      fails++;
      $display("FAIL hold_outputs: got A=%h B=%h OP=%h, want 1234 5678 25", a, b, op);
    end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'hC5);
    tests++;
    if ({done, a, b, op} !== {1'b1, 16'h0201, 16'h0403, 6'h05}) begin
      fails++;
      $display("FAIL next_frame: got done=%b A=%h B=%h OP=%h, want 1 0201 0403 05", done, a, b, op);
    end
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests++;
    if ({done, overrun} !== 2'b00) begin
      fails++;
      $display("FAIL ack_release: got done=%b ovr=%b, want 0 0", done, overrun);
    end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    send_byte(8'hAA); send_byte(8'hBB);
    for (int i = 1; i <= 49; i++) begin
      @(negedge clk);
      if (timeout) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL timeout_early: got %0d pulses, want 0", seen); end
    @(negedge clk);
`ifdef UART_FRAME_TIMEOUT_EN
    tests++;
    if ({timeout, dut.cnt_q} !== {1'b1, 3'd0}) begin
      fails++;
      $display("FAIL timeout_pulse: got tmo=%b cnt=%0d, want 1 0", timeout, dut.cnt_q);
    end
    @(negedge clk);
    tests++;
    if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_once: got %b want 0", timeout); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h3F);
    tests++;
    if ({done, a, b, op} !== {1'b1, 16'h2211, 16'h4433, 6'h3F}) begin
      fails++;
      $display("FAIL timeout_recover: got done=%b A=%h B=%h OP=%h, want 1 2211 4433 3F", done, a, b, op);
    end
`else
    tests++;
    if ({timeout, dut.cnt_q} !== {1'b0, 3'd2}) begin
      fails++;
      $display("FAIL no_timeout: got tmo=%b cnt=%0d, want 0 2", timeout, dut.cnt_q);
    end
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h3F);
    tests++;
    if ({done, a, b, op} !== {1'b1, 16'hBBAA, 16'h4433, 6'h3F}) begin
      fails++;
      $display("FAIL wait_forever: got done=%b A=%h B=%h OP=%h, want 1 BBAA 4433 3F", done, a, b, op);
    end
`endif
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({a, b, op, done, overrun, timeout, dut.cnt_q} !== '0) begin
      fails++;
      $display("FAIL reset_async: got A=%h B=%h OP=%h done=%b cnt=%0d, want all 0", a, b, op, done, dut.cnt_q);
    end
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_residue: got done=%b want 0", done); end
    send_byte(8'h7F);
    tests++;
    if ({done, a, b, op} !== {1'b1, 16'hCDAB, 16'h01EF, 6'h3F}) begin
      fails++;
      $display("FAIL reset_frame: got done=%b A=%h B=%h OP=%h, want 1 CDAB 01EF 3F", done, a, b, op);
    end
  endtask

  task automatic test_width8();
    logic [7:0] seq [3];
    seq[0] = 8'hAA; seq[1] = 8'h55; seq[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rx_done8 = 1'b1; data8 = seq[i];
      @(negedge clk); rx_done8 = 1'b0;
    end
    tests++;
    if ({done8, a8, b8, op8, overrun8, timeout8} !== {1'b1, 8'hAA, 8'h55, 8'hFF, 2'b00}) begin
      fails++;
      $display("FAIL width8_frame: got done=%b A=%h B=%h OP=%h, want 1 AA 55 FF", done8, a8, b8, op8);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_frame();
    test_overrun();
    test_ack_with_byte();
    test_timeout();
    test_reset_midframe();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits, legal values 8, 16, 24 or 32.
REQ-002 SHALL have parameter OP_W, default 6, opcode width in bits, legal values 1 to 8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, inter-byte idle limit in i_clk cycles, minimum 2.
REQ-004 SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port i_rx_done, input, 1 bit, a one-cycle strobe meaning i_data holds a received byte.
REQ-007 SHALL have port i_data, input, 8 bits, the received UART byte.
REQ-008 SHALL have port i_ack, input, 1 bit, the consumer accepting the presented frame.
REQ-009 SHALL have ports o_data_A and o_data_B, output, DATA_W bits each, the assembled operands.
REQ-010 SHALL have port o_data_OPCODE, output, OP_W bits, the assembled opcode.
REQ-011 SHALL have port o_done, output, 1 bit, the frame-valid level, held until acknowledged.
REQ-012 SHALL have ports o_overrun and o_timeout, output, 1 bit each, one-cycle error pulses.

Function
REQ-013 SHALL define NB = DATA_W/8 and FRAME_BYTES = 2*NB+1, with byte order A LSB-first, then B LSB-first, then the opcode byte.
REQ-014 SHALL take the opcode from opcode-byte bits [OP_W-1:0] and ignore the upper bits.
REQ-015 SHALL implement states IDLE (0 bytes held), COLLECT (1 to FRAME_BYTES-1 bytes held) and VALID (frame presented).
REQ-016 SHALL, in IDLE or COLLECT, store a byte on each i_rx_done, increment the byte counter, and move IDLE to COLLECT.
REQ-017 SHALL, on the edge that samples byte FRAME_BYTES, load o_data_A, o_data_B and o_data_OPCODE, clear the counter, enter VALID and assert o_done in the next cycle.
REQ-018 SHALL hold o_done and all data outputs stable throughout VALID.
REQ-019 SHALL, in VALID with i_ack=1, deassert o_done and return to IDLE; i_ack SHALL be ignored outside VALID.
REQ-020 SHALL, in VALID with i_rx_done=1 and i_ack=0, drop the byte, pulse o_overrun for one cycle and stay in VALID.
REQ-021 SHALL, in VALID with i_rx_done=1 and i_ack=1 in the same cycle, retire the frame and store the byte as byte 1 of a new frame (state COLLECT), with no overrun.
REQ-022 SHALL keep the data outputs at their last values in IDLE and COLLECT; only o_done qualifies them.
REQ-023 SHALL size the byte counter as clog2(FRAME_BYTES+1) bits, with no wrap-around beyond FRAME_BYTES.

Reset
REQ-024 SHALL, while i_reset=1, force state IDLE, counter 0, the timeout counter 0, all data outputs 0, and o_done, o_overrun and o_timeout to 0.
REQ-025 SHALL discard any partial or presented frame on reset, with no o_done afterwards for that frame.

Configuration
REQ-026 SHALL gate the inter-byte timeout with macro UART_FRAME_TIMEOUT_EN.
REQ-027 SHALL, with UART_FRAME_TIMEOUT_EN defined, count idle cycles in COLLECT, clear the count on each accepted byte, and on reaching TIMEOUT_CYC discard the partial frame, return to IDLE and pulse o_timeout once.
REQ-028 SHALL, with UART_FRAME_TIMEOUT_EN undefined, omit the timeout counter, let COLLECT wait indefinitely and tie o_timeout to 0.

Verification (DATA_W=16, OP_W=6, TIMEOUT_CYC=50 unless noted)
REQ-029 SHALL cover: bytes 34 12 78 56 E5 -> A=1234, B=5678, OPCODE=25, o_done high one cycle after byte 5.
REQ-030 SHALL cover: frame presented, byte sent without i_ack -> o_overrun pulses once, outputs unchanged, o_done still high.
REQ-031 SHALL cover: i_ack coincident with byte 01 of the next frame -> o_done low, counter=1, no overrun, the next frame completes normally.
REQ-032 SHALL cover, with UART_FRAME_TIMEOUT_EN defined: 2 bytes then 50 idle cycles -> o_timeout pulse, IDLE; the next 5 bytes form a correct frame.
REQ-033 SHALL cover: i_reset asserted after byte 3 -> all outputs 0 immediately; then 5 new bytes -> a correct frame with no residue.
REQ-034 SHALL cover, with DATA_W=8 and OP_W=8: bytes AA 55 FF -> A=AA, B=55, OPCODE=FF.
